// File: rtl/depth_sweep_ctrl.sv
// Sweeps a price range one limit at a time, querying an external volume-at-limit
// engine per level and accumulating a saturating cumulative volume.
module depth_sweep_ctrl #(
   parameter int LIM_W   = 16,
   parameter int ACC_W   = 24,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_start,
   input  logic             req_side,
   input  logic [LIM_W-1:0] req_lo,
   input  logic [LIM_W-1:0] req_hi,
   output logic             busy,
   output logic             lvl_valid,
   output logic [LIM_W-1:0] lvl_limit,
   output logic [LIM_W-1:0] lvl_volume,
   output logic [ACC_W-1:0] total,
   output logic             sweep_done,
   output logic             err,
   output logic             q_start,
   output logic             q_side,
   output logic [LIM_W-1:0] q_limit,
   input  logic [LIM_W-1:0] q_volume,
   input  logic             q_done
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      EMIT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             side_r;
   logic [LIM_W-1:0] cur_lim;
   logic [LIM_W-1:0] end_lim;
   logic [CNT_W-1:0] tmo_cnt;
   logic             err_flag;
   logic             range_bad;
   logic             last_lvl;
   logic             tmo_hit;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [LIM_W-1:0] vol);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + (ACC_W+1)'(vol);
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

   assign range_bad = (req_lo > req_hi);
   // Equality against the end limit keeps sweeps touching 0 or all-ones from wrapping.
   assign last_lvl  = (cur_lim == end_lim);
   assign tmo_hit   = (tmo_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_start) state_nxt = range_bad ? FIN : ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT: begin
            if (q_done)       state_nxt = EMIT;
            else if (tmo_hit) state_nxt = FIN;
         end
         EMIT:    state_nxt = last_lvl ? FIN : ISSUE;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      q_start    = (state == ISSUE);
      lvl_valid  = (state == EMIT);
      sweep_done = (state == FIN);
      err        = (state == FIN) && err_flag;
   end

   assign q_side  = side_r;
   assign q_limit = cur_lim;

   always_ff @(posedge clk) begin
      if (rst) begin
         side_r     <= 1'b0;
         cur_lim    <= '0;
         end_lim    <= '0;
         tmo_cnt    <= '0;
         err_flag   <= 1'b0;
         lvl_limit  <= '0;
         lvl_volume <= '0;
         total      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_start) begin
                  side_r   <= req_side;
                  cur_lim  <= req_side ? req_lo : req_hi;
                  end_lim  <= req_side ? req_hi : req_lo;
                  total    <= '0;
                  tmo_cnt  <= '0;
                  err_flag <= range_bad;
               end
            end
            ISSUE: tmo_cnt <= '0;
            WAIT: begin
               // Result is registered on q_done so total and lvl_* line up with lvl_valid.
               if (q_done) begin
                  lvl_volume <= q_volume;
                  lvl_limit  <= cur_lim;
                  total      <= sat_add(total, q_volume);
               end else if (tmo_hit) begin
                  err_flag <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            EMIT: begin
               if (!last_lvl) cur_lim <= side_r ? cur_lim + LIM_W'(1) : cur_lim - LIM_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_depth_sweep_ctrl.sv
// Randomized bench for depth_sweep_ctrl: an engine model answers queries and a
// list-based reference predicts the sweep order, levels and saturating totals.
module tb_depth_sweep_ctrl;

   localparam int LIM_W   = 16;
   localparam int ACC_W   = 24;
   localparam int TIMEOUT = 255;
   localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_start = 1'b0;
   logic             req_side = 1'b0;
   logic [LIM_W-1:0] req_lo = '0;
   logic [LIM_W-1:0] req_hi = '0;
   logic             busy;
   logic             lvl_valid;
   logic [LIM_W-1:0] lvl_limit;
   logic [LIM_W-1:0] lvl_volume;
   logic [ACC_W-1:0] total;
   logic             sweep_done;
   logic             err;
   logic             q_start;
   logic             q_side;
   logic [LIM_W-1:0] q_limit;
   logic [LIM_W-1:0] q_volume = '0;
   logic             q_done = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;
   int vol_list[$];

   depth_sweep_ctrl #(.LIM_W(LIM_W), .ACC_W(ACC_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_start(req_start), .req_side(req_side),
      .req_lo(req_lo), .req_hi(req_hi), .busy(busy), .lvl_valid(lvl_valid),
      .lvl_limit(lvl_limit), .lvl_volume(lvl_volume), .total(total),
      .sweep_done(sweep_done), .err(err), .q_start(q_start), .q_side(q_side),
      .q_limit(q_limit), .q_volume(q_volume), .q_done(q_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint sat(input longint s);
      return (s > ACC_MAX) ? ACC_MAX : s;
   endfunction

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_lvl_valid"}, lvl_valid, 0);
      check_val({tag, "_lvl_limit"}, lvl_limit, 0);
      check_val({tag, "_lvl_volume"}, lvl_volume, 0);
      check_val({tag, "_total"}, total, 0);
      check_val({tag, "_sweep_done"}, sweep_done, 0);
      check_val({tag, "_err"}, err, 0);
      check_val({tag, "_q_start"}, q_start, 0);
      check_val({tag, "_q_side"}, q_side, 0);
      check_val({tag, "_q_limit"}, q_limit, 0);
   endtask

   // dly=0 picks a random engine latency; silent_at>=0 makes the engine never answer that level.
   task automatic run_sweep(input logic side, input logic [LIM_W-1:0] lo, input logic [LIM_W-1:0] hi,
                            input int dly, input int silent_at, input bit noise);
      logic [LIM_W-1:0] lims[$];
      longint sum;
      int d;
      logic [LIM_W-1:0] v;
      if (lo <= hi) begin
         if (side) for (longint l = longint'(lo); l <= longint'(hi); l++) lims.push_back(l[LIM_W-1:0]);
         else      for (longint l = longint'(hi); l >= longint'(lo); l--) lims.push_back(l[LIM_W-1:0]);
      end
      @(negedge clk);
      req_start = 1'b1; req_side = side; req_lo = lo; req_hi = hi;
      @(negedge clk);
      req_start = 1'b0; req_side = ~side; req_lo = LIM_W'($urandom); req_hi = LIM_W'($urandom);
      if (lims.size() == 0) begin
         check_val("empty_q_start", q_start, 0);
         check_val("empty_done", sweep_done, 1);
         check_val("empty_err", err, 1);
         check_val("empty_total", total, 0);
         @(negedge clk);
         check_val("empty_busy", busy, 0);
         check_val("empty_done_clr", sweep_done, 0);
         return;
      end
      sum = 0;
      for (int k = 0; k < lims.size(); k++) begin
         check_val("q_start", q_start, 1);
         check_val("q_limit", q_limit, lims[k]);
         check_val("q_side", q_side, side);
         check_val("busy", busy, 1);
         if (k == silent_at) begin
            int cyc = 0;
            bit seen_lvl = 0;
            while (!sweep_done && cyc < 1000) begin
               @(negedge clk);
               cyc++;
               if (lvl_valid) seen_lvl = 1;
            end
            check_val("tmo_latency", cyc, TIMEOUT + 1);
            check_val("tmo_err", err, 1);
            check_val("tmo_total", total, sat(sum));
            check_val("tmo_no_lvl", seen_lvl, 0);
            @(negedge clk);
            check_val("tmo_busy", busy, 0);
            return;
         end
         d = (dly > 0) ? dly : $urandom_range(1, 4);
         v = (vol_list.size() > 0) ? LIM_W'(vol_list.pop_front()) : LIM_W'($urandom);
         for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            req_start = 1'b0;
            if (noise && j == 1 && $urandom_range(0, 1) == 1) begin
               req_start = 1'b1; req_side = ~side;
               req_lo = LIM_W'($urandom); req_hi = LIM_W'($urandom);
            end
            check_val("hold_limit", q_limit, lims[k]);
            check_val("hold_side", q_side, side);
            check_val("wait_q_start", q_start, 0);
            if (j == d) begin q_done = 1'b1; q_volume = v; end
         end
         @(negedge clk);
         req_start = 1'b0;
         q_done = noise && ($urandom_range(0, 1) == 1);
         q_volume = LIM_W'($urandom);
         sum += longint'(v);
         check_val("lvl_valid", lvl_valid, 1);
         check_val("lvl_limit", lvl_limit, lims[k]);
         check_val("lvl_volume", lvl_volume, v);
         check_val("lvl_total", total, sat(sum));
         @(negedge clk);
         q_done = 1'b0;
         check_val("lvl_valid_clr", lvl_valid, 0);
         if (k == lims.size() - 1) begin
            check_val("fin_done", sweep_done, 1);
            check_val("fin_err", err, 0);
            check_val("fin_q_start", q_start, 0);
            check_val("fin_total", total, sat(sum));
            if (noise) begin
               req_start = 1'b1; req_side = ~side;
               req_lo = LIM_W'($urandom); req_hi = LIM_W'($urandom);
            end
            @(negedge clk);
            req_start = 1'b0;
            check_val("idle_busy", busy, 0);
            check_val("idle_done_clr", sweep_done, 0);
            check_val("idle_total_hold", total, sat(sum));
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("post_reset");

      vol_list = '{5, 0, 7};
      run_sweep(1'b1, 16'd1, 16'd3, 3, -1, 1'b0);
      run_sweep(1'b0, 16'd10, 16'd12, 0, -1, 1'b1);
      run_sweep(1'b1, 16'd5, 16'd4, 0, -1, 1'b0);
      run_sweep(1'b1, 16'hFFFF, 16'hFFFF, 0, -1, 1'b1);
      run_sweep(1'b0, 16'd0, 16'd2, 0, -1, 1'b1);
      vol_list = '{9};
      run_sweep(1'b1, 16'd20, 16'd25, 0, 1, 1'b0);

      // Reset while waiting on the engine, then a late q_done.
      @(negedge clk);
      req_start = 1'b1; req_side = 1'b1; req_lo = 16'd100; req_hi = 16'd102;
      @(negedge clk);
      req_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; q_done = 1'b1; q_volume = 16'h1234;
      check_all_zero("mid_wait_rst");
      @(negedge clk);
      q_done = 1'b0;
      check_val("rst_qdone_lvl", lvl_valid, 0);
      check_val("rst_qdone_busy", busy, 0);
      check_val("rst_qdone_total", total, 0);
      run_sweep(1'b1, 16'd100, 16'd102, 0, -1, 1'b1);

      for (int s = 0; s < 25; s++) begin
         logic [LIM_W-1:0] lo;
         logic [LIM_W-1:0] hi;
         lo = ($urandom_range(0, 3) == 0) ? LIM_W'(16'hFFF8 + $urandom_range(0, 7)) : LIM_W'($urandom);
         if ($urandom_range(0, 7) == 0 && lo != 0) hi = lo - 16'd1;
         else hi = (longint'(lo) + 6 > 65535) ? 16'hFFFF : lo + LIM_W'($urandom_range(0, 6));
         run_sweep(1'($urandom_range(0, 1)), lo, hi, 0, -1, 1'b1);
      end

      // Long all-max sweep that ends at the top limit and drives total into saturation.
      for (int i = 0; i < 272; i++) vol_list.push_back(16'hFFFF);
      run_sweep(1'b1, 16'hFEF0, 16'hFFFF, 1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
